// File: rtl/decoder_pkg.sv
// Shared state encoding and one-hot decode helper for the sequenced select decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    SWEEP = 2'b10
  } state_e;

  // Widest select the helper can build; callers size-cast down to their DEPTH.
  localparam int unsigned ONEHOT_MAX_W = 256;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [31:0] addr,
                                                      input int unsigned depth);
    onehot = '0;
    if (addr < depth) onehot[addr[7:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/mod_addr_counter.sv
// Mod-DEPTH up-counter with load (priority over inc) and a registered wrap pulse.
module mod_addr_counter #(
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      wrap_d = (addr_q == LAST);
      addr_d = wrap_d ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_o = addr_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered address-to-one-hot select with hold, single step and automatic sweep.
// Optional sticky one-hot checker on err: define DECODER_ONEHOT_CHECK_EN.
module seq_onehot_decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              enable,
  input  logic              step,
  input  logic              sweep,
  output logic [DEPTH-1:0]  out,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              bad_addr,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic              done_q, done_d;
  logic              ctr_load, ctr_inc;
  logic [DEPTH-1:0]  dec;

  mod_addr_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (ctr_load),
    .load_val_i (address),
    .inc_i      (ctr_inc),
    .addr_o     (cur_addr),
    .wrap_o     (wrap)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bad_d    = 1'b0;
    done_d   = 1'b0;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (load) begin
          if ({1'b0, address} < DEPTH_X) begin
            ctr_load = 1'b1;
            state_d  = enable ? HOLD : IDLE;
          end else begin
            bad_d = 1'b1;
          end
        end else if (sweep) begin
          cnt_d   = '0;
          state_d = SWEEP;
        end else if (step && state_q == HOLD) begin
          ctr_inc = 1'b1;
        end
      end
      SWEEP: begin
        // The final increment lands back on the start index, so no reload is needed.
        ctr_inc = 1'b1;
        cnt_d   = cnt_q + (ADDR_W+1)'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
    end
  end

  assign dec      = DEPTH'(onehot(32'(cur_addr), DEPTH));
  assign out      = (state_q == HOLD || state_q == SWEEP) ? dec : '0;
  assign busy     = (state_q == SWEEP);
  assign done     = done_q;
  assign bad_addr = bad_q;

`ifdef DECODER_ONEHOT_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (((out & (out - DEPTH'(1))) != '0) || (state_q == IDLE && out != '0)) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/seq_onehot_decoder.md
Name: seq_onehot_decoder

Overview:
- Parametrised registered successor to the 2-to-4 enable decoder: ADDR_W-bit address to DEPTH-wide one-hot select, with DEPTH at most 2^ADDR_W.
- Adds a held select state, single-step advance with wrap-around, and an automatic full sweep across all DEPTH outputs.
- Drives row/register write-selects and scan sequencing in the datapath.

Parameters:
- ADDR_W, 2, address width in bits.
- DEPTH, 4, number of one-hot outputs; legal range 1..2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  capture address/enable this cycle
- address  in  ADDR_W  select index to load
- enable  in  1  with load: 1 = HOLD (output on), 0 = IDLE (output off)
- step  in  1  advance the held select by one position
- sweep  in  1  start an automatic full sweep
- out  out  DEPTH  one-hot select, all zero when disabled
- cur_addr  out  ADDR_W  current index
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- wrap  out  1  one-cycle pulse on DEPTH-1 -> 0 wrap
- bad_addr  out  1  one-cycle pulse when a load address is at or above DEPTH
- err  out  1  one-hot checker flag (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cur_addr=0, out=0, busy=done=wrap=bad_addr=err=0, immediately, mid-sweep included.
- States: IDLE (out=0), HOLD (out=1<<cur_addr), SWEEP (out=1<<cur_addr, busy=1).
- All outputs are registers or pure decodes of registers; no combinational input-to-output path.
- Load latency is 1 cycle: a load sampled at edge T appears on out after T.
- IDLE/HOLD input priority: load > sweep > step.
  - load with address < DEPTH: cur_addr<=address; next state is HOLD if enable=1, otherwise IDLE.
  - load with address >= DEPTH: state and cur_addr unchanged; bad_addr=1 for the next cycle.
  - step in HOLD: cur_addr<=(cur_addr==DEPTH-1)?0:cur_addr+1. When it wraps, wrap=1 in the cycle where cur_addr first reads 0.
  - step in IDLE: ignored.
  - sweep in IDLE or HOLD: records start=cur_addr, clears the internal counter cnt, state<=SWEEP.
- SWEEP:
  - Each cycle, cur_addr advances modulo DEPTH and cnt increments.
  - out shows start, start+1, ..., start+DEPTH-1 (mod DEPTH), one cycle each.
  - On the edge where cnt==DEPTH-1: cur_addr returns to start, state<=HOLD, done=1 in the first HOLD cycle, busy falls in that same cycle.
  - wrap pulses inside a sweep exactly as for step.
  - load, step and sweep are ignored in SWEEP.
- DEPTH=1: cur_addr stays 0. A step or sweep produces wrap=1 each time. A sweep lasts one cycle, then done.
- Widths: cnt is ADDR_W+1 bits wide. All comparisons are unsigned.

Optional Feature:
- Macro DECODER_ONEHOT_CHECK_EN.
- Defined: sticky err sets on any cycle where out has more than one bit set, or out≠0 in IDLE. Only reset clears it.
- Undefined: err is tied to 0 and no checker logic is synthesised.

Decomposition:
- Package decoder_pkg holds:
  - state encoding constants: IDLE=2'b00, HOLD=2'b01, SWEEP=2'b10
  - a onehot(addr, DEPTH) function.
- One sub-module, mod_addr_counter: mod-DEPTH up-counter with load, inc, and a registered wrap pulse. It is used for cur_addr.

Test Plan (ADDR_W=3, DEPTH=6):
- Reset, then load address=5 enable=1 -> next cycle out=6'b100000, cur_addr=5, bad_addr=0.
- From HOLD@5, step=1 -> out=6'b000001, cur_addr=0, wrap=1 for exactly one cycle.
- load address=6 enable=1 -> bad_addr=1 for one cycle; out and cur_addr unchanged.
- HOLD@2, sweep=1 -> out walks 2,3,4,5,0,1 over 6 cycles with busy=1 and wrap=1 when 0 is shown. The next cycle is HOLD@2 with done=1 and busy=0.
- load=1 and step=1 in the same cycle, address=3 -> cur_addr=3 (load wins). load enable=0 -> out=0, state IDLE.
- reset_n low during the third sweep cycle -> out=0 and busy=0 with no clock edge; cur_addr=0. After release, step is ignored while in IDLE.
